// File: rtl/count_display_pkg.sv
// count_display_pkg: shared types, constants and helpers for the
// count_display_driver slice (glyph encoder, BCD digit adjust, converter states).
package count_display_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  localparam seg_t BLANK_GLYPH = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Active-low seven-segment pattern {g,f,e,d,c,b,a}; b and d are lowercase shapes.
  function automatic seg_t glyph(digit_t d);
    seg_t s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Add 3 to every BCD digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [35:0] bcd_adjust(logic [35:0] v);
    logic [35:0] r;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (v[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/count_display_driver_bin_to_bcd.sv
// bin_to_bcd: sequential shift-add-3 binary to 9-digit BCD converter.
// One load cycle, BIN_W shift cycles, then a single-cycle done pulse.
// A start seen while busy is ignored.
module bin_to_bcd
  import count_display_pkg::*;
#(
  parameter int BIN_W = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [35:0]      bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

  conv_state_t      state, state_next;
  logic [BIN_W-1:0] bin_sr, bin_next;
  logic [35:0]      bcd_sr, bcd_next;
  logic [CNT_W-1:0] shift_cnt, cnt_next;
  logic [35:0]      bcd_adj;

  // Register the FSM state together with the shift datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bin_sr    <= '0;
      bcd_sr    <= '0;
      shift_cnt <= '0;
    end else begin
      state     <= state_next;
      bin_sr    <= bin_next;
      bcd_sr    <= bcd_next;
      shift_cnt <= cnt_next;
    end
  end

  // Next-state and datapath: load on start, adjust-and-shift BIN_W times, pulse done.
  always_comb begin
    state_next = state;
    bin_next   = bin_sr;
    bcd_next   = bcd_sr;
    cnt_next   = shift_cnt;
    bcd_adj    = bcd_adjust(bcd_sr);
    case (state)
      IDLE: begin
        if (start) begin
          bin_next   = bin;
          bcd_next   = '0;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bcd_next = {bcd_adj[34:0], bin_sr[BIN_W-1]};
        bin_next = {bin_sr[BIN_W-2:0], 1'b0};
        cnt_next = shift_cnt + 1'b1;
        if (shift_cnt == LAST_SHIFT) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign bcd  = bcd_sr;

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: samples the count bus once per frame and scans it
// onto an 8-digit common-anode seven-segment display.
// Optional macro COUNT_DISPLAY_BCD_EN: decimal rendering through bin_to_bcd,
// with digit 7's decimal point flagging values >= 100,000,000.
// Without it the value is rendered in hex on digits 0..6.
module count_display_driver
  import count_display_pkg::*;
#(
  parameter int COUNT_W      = 28,
  parameter int DIGIT_CYCLES = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COUNT_W-1:0] countIn,
  output logic [6:0]         seg,
  output logic               dp,
  output logic [7:0]         an
);

  localparam int DISP_W    = 4 * NUM_DIGITS;
  localparam int REFRESH_W = $clog2(DIGIT_CYCLES);
  localparam logic [REFRESH_W-1:0] REFRESH_MAX = REFRESH_W'(DIGIT_CYCLES - 1);
  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

  generate
    if (DIGIT_CYCLES < 32) begin : g_bad_digit_cycles
      $error("count_display_driver: DIGIT_CYCLES must be at least 32");
    end
  endgenerate

  logic [REFRESH_W-1:0] refresh_cnt;
  logic [2:0]           digit_idx;
  logic                 frame_start;
  logic [COUNT_W-1:0]   snap_reg;
  logic                 load_pending;
  logic [DISP_W-1:0]    digit_reg;
  digit_t               cur_digit;

  assign frame_start = (digit_idx == 3'd0) && (refresh_cnt == '0);

  // Per-digit dwell counter; each wrap advances the scanned digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 3'd0;
    end else if (refresh_cnt == REFRESH_MAX) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 3'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Snapshot the count only at frame start so a frame never shows a torn value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_reg     <= '0;
      load_pending <= 1'b0;
    end else begin
      load_pending <= frame_start;
      if (frame_start) begin
        snap_reg <= countIn;
      end
    end
  end

`ifdef COUNT_DISPLAY_BCD_EN
  logic        conv_busy;
  logic        conv_done;
  logic [35:0] conv_bcd;
  logic        ovf_reg;

  bin_to_bcd #(
    .BIN_W(COUNT_W)
  ) u_bin_to_bcd (
    .clk   (clk),
    .reset (reset),
    .start (load_pending & ~conv_busy),
    .bin   (snap_reg),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Swap in all decimal digits at once when the converter finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (conv_done) begin
      digit_reg <= conv_bcd[DISP_W-1:0];
      ovf_reg   <= |conv_bcd[35:DISP_W];
    end
  end
`else
  // Hex digits are simply the snapshot, loaded the cycle after capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit_reg <= '0;
    end else if (load_pending) begin
      digit_reg <= DISP_W'(snap_reg);
    end
  end
`endif

  // Select the nibble belonging to the digit currently being scanned.
  always_comb begin
    cur_digit = 4'h0;
    cur_digit = digit_reg[{digit_idx, 2'b00} +: 4];
  end

  // Anode, segment and dp registers all update together to avoid ghosting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= BLANK_GLYPH;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'h01 << digit_idx);
      seg <= glyph(cur_digit);
      dp  <= 1'b1;
`ifdef COUNT_DISPLAY_BCD_EN
      if (digit_idx == LAST_DIGIT) begin
        dp <= ~ovf_reg;
      end
`else
      if (digit_idx == LAST_DIGIT) begin
        an  <= 8'hFF;
        seg <= BLANK_GLYPH;
      end
`endif
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// tb_count_display_driver: randomized bench for count_display_driver with a
// behavioural model of what each digit should show, in hex or decimal.
module tb_count_display_driver;

  localparam int DC      = 32;
  localparam int FRAME   = 8 * DC;
  localparam int COUNT_W = 28;
`ifdef COUNT_DISPLAY_BCD_EN
  localparam bit BCD_MODE = 1'b1;
  localparam int LAT      = COUNT_W + 4;
`else
  localparam bit BCD_MODE = 1'b0;
  localparam int LAT      = 3;
`endif

  logic               clk;
  logic               reset;
  logic [COUNT_W-1:0] count_in;
  logic [6:0]         seg;
  logic               dp;
  logic [7:0]         an;

  int compare_count  = 0;
  int mismatch_count = 0;
  int k_edges        = 0;
  logic [COUNT_W-1:0] cap_q[$];

  string lit_segs[16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                          "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                          "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  count_display_driver #(
    .COUNT_W      (COUNT_W),
    .DIGIT_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .countIn (count_in),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s at edge %0d: got %h, expected %h", tag, k_edges,
               observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [COUNT_W-1:0] v);
    count_in = v;
  endtask

  // Active-low segment pattern built from the list of lit segment letters.
  function automatic logic [6:0] glyph_of(int v);
    logic [6:0] mask;
    string s;
    mask = 7'h7F;
    s = lit_segs[v];
    for (int i = 0; i < s.len(); i++) begin
      mask[int'(s[i]) - 97] = 1'b0;
    end
    return mask;
  endfunction

  // Expected outputs after edge k_edges: the digit scanned in the previous
  // cycle, showing the newest frame snapshot whose display latency has elapsed.
  task automatic compare_to_model();
    int         p;
    int         d;
    longint     v;
    longint     div;
    int         digit;
    logic [7:0] exp_an;
    logic       exp_dp;
    p = k_edges - 1;
    d = (p / DC) % 8;
    v = 0;
    for (int f = 0; f < cap_q.size(); f++) begin
      if (f * FRAME + LAT <= k_edges) v = longint'(cap_q[f]);
    end
    if (BCD_MODE) begin
      div = 1;
      repeat (d) div = div * 10;
      digit = int'((v / div) % 10);
    end else begin
      digit = int'((v >> (4 * d)) & 15);
    end
    exp_an = ~(8'h01 << d);
    if (!BCD_MODE && d == 7) exp_an = 8'hFF;
    exp_dp = 1'b1;
    if (BCD_MODE && d == 7 && v >= 100_000_000) exp_dp = 1'b0;
    checkOutput("an", {24'h0, an}, {24'h0, exp_an});
    if (BCD_MODE || d != 7) begin
      checkOutput("seg", {25'h0, seg}, {25'h0, glyph_of(digit)});
    end
    checkOutput("dp", {31'h0, dp}, {31'h0, exp_dp});
  endtask

  task automatic tick();
    if (k_edges % FRAME == 0) cap_q.push_back(count_in);
    @(posedge clk);
    k_edges++;
    @(negedge clk);
    compare_to_model();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_an"}, {24'h0, an}, 32'hFF);
    checkOutput({tag, "_seg"}, {25'h0, seg}, 32'h7F);
    checkOutput({tag, "_dp"}, {31'h0, dp}, 32'h1);
  endtask

  // Assert reset asynchronously between edges, then release on a negedge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_values(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values({tag, "_hold"});
    reset = 1'b0;
    k_edges = 0;
    cap_q.delete();
  endtask

  initial begin
    int change_at;
    int guard;
    reset = 1'b1;
    count_in = COUNT_W'($urandom());
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b0;
    k_edges = 0;

    // Directed: hex pattern, then a mid-frame change that must not tear.
    applyStimulus(28'h0ABCDEF);
    run_ticks(FRAME + FRAME / 2);
    applyStimulus(28'h1234567);
    run_ticks(FRAME + FRAME / 2);
    applyStimulus(28'd12_345_678);
    run_ticks(FRAME + FRAME / 4);
    applyStimulus(28'hFFFFFFF);
    run_ticks(2 * FRAME);

    // Random values changing at random points inside frames.
    for (int f = 0; f < 6; f++) begin
      change_at = int'($urandom_range(1, FRAME - 1));
      run_ticks(change_at);
      if ($urandom_range(0, 1) == 1) applyStimulus(COUNT_W'($urandom()));
      else applyStimulus(COUNT_W'($urandom_range(0, 99_999_999)));
      run_ticks(FRAME - change_at);
    end

    // Reset five cycles after a capture, while a conversion would be running.
    guard = 0;
    while (k_edges % FRAME != 6 && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
    checkOutput("reach_midconv", guard < 2 * FRAME, 32'h1);
    async_reset("midconv");
    applyStimulus(COUNT_W'($urandom()));
    run_ticks(3 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count,
             mismatch_count);
    $finish;
  end

endmodule
